fbc_vout_burst_reader: RTL and testbench
========================================

# fbc_vout_burst_reader

Single-clock, parametrised DDR read-back engine for the FBC video-out path. It tracks the writer's burst-line counter, issues one DDR read burst per completed line into a line ring, and unpacks each wide memory word into DATA_WIDTH output words. Output goes through an internal buffer with credit-based flow control. It sits between the DDR arbiter read port and the downstream FBC consumer. Unlike the previous generation, it has configurable depth, base address, ring size and width ratio, plus error reporting and a fill-level output.

## Interface
- ADDR_WIDTH, 30, DDR byte-address width
- DATA_WIDTH, 32, output word width; MEM_DATA_BITS/DATA_WIDTH = RATIO, a power of two ≥1
- MEM_DATA_BITS, 256, DDR data width
- BURST_LEN, 64, MEM words per line burst; 1..255
- LINE_WIDTH, 18, burst-line counter width
- RING_LINES, 4096, lines in the DDR ring, a power of two ≤ 2^LINE_WIDTH
- BASE_ADDR, 0, ring byte base address
- BUF_DEPTH, 256, internal buffer depth in MEM words; ≥ BURST_LEN, a power of two

- ddr_clk_i  in  1  sole clock
- ddr_rst_i  in  1  synchronous, active-high reset
- scan_en_i  in  1  scan active level
- wr_burst_line_i  in  LINE_WIDTH  lines fully written by the writer (free-running, wraps)
- rd_burst_line_o  out  LINE_WIDTH  lines fully fetched
- fbc_start_o  out  1  level: first line buffered in this scan
- rd_ddr_req_o  out  1  one-cycle burst request
- rd_ddr_len_o  out  8  = BURST_LEN
- rd_ddr_addr_o  out  ADDR_WIDTH  burst byte address
- rd_ddr_data_valid_i  in  1  beat strobe
- rd_ddr_data_i  in  MEM_DATA_BITS  beat data
- rd_ddr_finish_i  in  1  burst complete pulse
- vout_rd_en_i  in  1  consumer read
- vout_rd_vld_o  out  1  read data valid
- vout_rd_data_o  out  DATA_WIDTH  read data
- vout_empty_o  out  1  no output word available
- vout_level_o  out  $clog2(BUF_DEPTH)+1  buffered MEM words
- err_o  out  2  sticky: [0] unexpected/excess beat, [1] short burst

## Operation
- FSM states: IDLE, REQ, READ, CHECK.
- IDLE → REQ requires all of the following:
  - scan_en_i = 1
  - wr_burst_line_i ≠ rd_line
  - BUF_DEPTH − level − 0 ≥ BURST_LEN
- REQ lasts one cycle. It asserts rd_ddr_req_o, sets addr = BASE_ADDR + (rd_line mod RING_LINES)·BURST_LEN·(MEM_DATA_BITS/8), truncated to ADDR_WIDTH, then goes to READ.
- READ: each data_valid beat is pushed into the buffer and beat_cnt is incremented. On rd_ddr_finish_i the FSM goes to CHECK.
- CHECK:
  - If beat_cnt ≠ BURST_LEN, set err_o[1].
  - In both cases rd_line increments (mod 2^LINE_WIDTH) and the FSM returns to IDLE.
- A data_valid outside READ, or beat_cnt exceeding BURST_LEN, sets err_o[0]. The beat is dropped.
- Line counter wrap: the difference wr−rd is computed modulo 2^LINE_WIDTH.
- Unpacking: each MEM word yields RATIO output words, least-significant DATA_WIDTH slice first. A MEM word is popped after its last slice is read.
- fbc_start_o sets at the CHECK of the first line after scan_en_i rises. It clears when scan_en_i = 0.
- scan_en_i falling edge:
  - An in-flight burst completes normally; no new requests are issued.
  - On the next rising edge, rd_line and the buffer reset to 0 while in IDLE.
- Reset mid-burst: the FSM returns to IDLE and remaining beats are ignored. The error is not flagged until the next REQ.

## Timing
- Reset values: all outputs 0, except vout_empty_o = 1 and rd_ddr_len_o = BURST_LEN. err_o clears only on reset.
- Request latency: rd_ddr_req_o is high 2 cycles after the request condition becomes true (IDLE→REQ registered).
- Buffer write is 1 cycle after data_valid. vout_empty_o deasserts 1 cycle after that.
- Standard mode: vout_rd_vld_o and data appear 1 cycle after vout_rd_en_i. A read while empty is ignored (no vld).
- Simultaneous push and slice-pop-last in one cycle: level is unchanged.
- rd_burst_line_o updates in the cycle after CHECK.

## Configuration
- FBC_VOUT_FWFT_EN defined: first-word-fall-through. vout_rd_data_o is valid whenever vout_empty_o = 0, vout_rd_vld_o = ~vout_empty_o, and vout_rd_en_i advances the slice.
- Undefined: standard read mode with 1-cycle latency, as described in Timing.

## Test plan
- Reset, scan_en=1, wr_burst_line 0→1, BURST_LEN=4 beats → one req with addr=BASE_ADDR and len=4. After finish, rd_burst_line_o=1, fbc_start_o=1, and 32 words out in slice order.
- Consumer stalled, BUF_DEPTH=8, BURST_LEN=4, wr=5 → exactly 2 bursts issued; the third is issued only after level ≤ 4.
- rd_line=RING_LINES−1 → addr = BASE_ADDR + (RING_LINES−1)·BURST_LEN·32. The next burst uses addr=BASE_ADDR. At wr wrapping from 2^18−1 to 0, requests continue.
- finish after 3 of 4 beats → err_o=2'b10 and rd_burst_line_o still increments. A stray data_valid in IDLE → err_o[0]=1.
- scan_en drops during READ → the burst completes, no further req, fbc_start_o=0. scan_en re-rises → rd_burst_line_o=0.
- With FBC_VOUT_FWFT_EN: data is present with empty=0 before any rd_en. Without it: vld appears exactly 1 cycle after rd_en.

Source files
------------

// File: rtl/fbc_vout_burst_reader.sv
// rtl/fbc_vout_burst_reader.sv - DDR line-ring read-back engine with word unpacking buffer.
// Optional FBC_VOUT_FWFT_EN selects first-word-fall-through output instead of 1-cycle read latency.
module fbc_vout_burst_reader #(
    parameter int                    ADDR_WIDTH    = 30,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    MEM_DATA_BITS = 256,
    parameter int                    BURST_LEN     = 64,
    parameter int                    LINE_WIDTH    = 18,
    parameter int                    RING_LINES    = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                    BUF_DEPTH     = 256
) (
    input  logic                           ddr_clk_i,
    input  logic                           ddr_rst_i,
    input  logic                           scan_en_i,
    input  logic [LINE_WIDTH-1:0]          wr_burst_line_i,
    output logic [LINE_WIDTH-1:0]          rd_burst_line_o,
    output logic                           fbc_start_o,
    output logic                           rd_ddr_req_o,
    output logic [7:0]                     rd_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]          rd_ddr_addr_o,
    input  logic                           rd_ddr_data_valid_i,
    input  logic [MEM_DATA_BITS-1:0]       rd_ddr_data_i,
    input  logic                           rd_ddr_finish_i,
    input  logic                           vout_rd_en_i,
    output logic                           vout_rd_vld_o,
    output logic [DATA_WIDTH-1:0]          vout_rd_data_o,
    output logic                           vout_empty_o,
    output logic [$clog2(BUF_DEPTH):0]     vout_level_o,
    output logic [1:0]                     err_o
);
    localparam int RATIO      = MEM_DATA_BITS / DATA_WIDTH;
    localparam int SW         = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int AW         = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int LW         = $clog2(BUF_DEPTH) + 1;
    localparam int LINE_BYTES = BURST_LEN * (MEM_DATA_BITS / 8);

    typedef enum logic [1:0] {IDLE, REQ, READ, CHECK} state_t;

    state_t                   state_q, state_d;
    logic [LINE_WIDTH-1:0]    rd_line_q, rd_line_d;
    logic [8:0]               beat_cnt_q, beat_cnt_d;
    logic [1:0]               err_q, err_d;
    logic                     fbc_start_q, fbc_start_d;
    logic                     req_q, req_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     scan_q;
    logic                     restart_q, restart_d;
    logic                     ignore_q, ignore_d;
    logic                     push_q, push_d;
    logic [MEM_DATA_BITS-1:0] push_data_q, push_data_d;
    logic [AW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic [SW-1:0]            slice_q, slice_d;

    logic [MEM_DATA_BITS-1:0] buf_mem [BUF_DEPTH];
    logic [MEM_DATA_BITS-1:0] rd_word;
    logic [DATA_WIDTH-1:0]    slice_word;
    logic [LINE_WIDTH-1:0]    ring_idx;
    logic                     clear, beat_ok, has_space, rd_fire, pop, push_en;

    always_comb begin
        state_d     = state_q;
        rd_line_d   = rd_line_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        fbc_start_d = fbc_start_q;
        req_d       = 1'b0;
        addr_d      = addr_q;
        ignore_d    = ignore_q;
        // A scan restart is deferred until any in-flight burst has drained back to IDLE.
        restart_d   = restart_q | (scan_en_i & ~scan_q);
        clear       = (state_q == IDLE) && restart_d;
        ring_idx    = rd_line_q & LINE_WIDTH'(RING_LINES - 1);
        has_space   = (LW'(BUF_DEPTH) - level_q) >= LW'(BURST_LEN);
        beat_ok     = rd_ddr_data_valid_i && (state_q == READ) && (beat_cnt_q < 9'(BURST_LEN));
        push_d      = beat_ok;
        push_data_d = rd_ddr_data_i;

        if (rd_ddr_data_valid_i && !beat_ok && !ignore_q) begin
            err_d[0] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (clear) begin
                    rd_line_d = '0;
                    restart_d = 1'b0;
                end else if (scan_en_i && (wr_burst_line_i - rd_line_q) != '0 && has_space) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                req_d      = 1'b1;
                addr_d     = ADDR_WIDTH'(64'(BASE_ADDR) + 64'(ring_idx) * 64'(LINE_BYTES));
                beat_cnt_d = '0;
                ignore_d   = 1'b0;
                state_d    = READ;
            end
            READ: begin
                if (beat_ok) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                end
                if (rd_ddr_finish_i) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (beat_cnt_q != 9'(BURST_LEN)) begin
                    err_d[1] = 1'b1;
                end
                rd_line_d = rd_line_q + LINE_WIDTH'(1);
                if (scan_en_i) begin
                    fbc_start_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!scan_en_i) begin
            fbc_start_d = 1'b0;
        end
    end

    always_comb begin
        rd_word    = buf_mem[rptr_q];
        slice_word = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (slice_q == SW'(i)) begin
                slice_word = rd_word[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        rd_fire = vout_rd_en_i && (level_q != '0) && !clear;
        pop     = rd_fire && (slice_q == SW'(RATIO - 1));
        push_en = push_q && ((level_q != LW'(BUF_DEPTH)) || pop) && !clear;

        slice_d = slice_q;
        if (rd_fire) begin
            slice_d = pop ? '0 : slice_q + SW'(1);
        end
        wptr_d  = push_en ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        level_d = level_q;
        case ({push_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (clear) begin
            slice_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge ddr_clk_i) begin
        if (push_en) begin
            buf_mem[wptr_q] <= push_data_q;
        end
    end

    always_ff @(posedge ddr_clk_i) begin
        if (ddr_rst_i) begin
            state_q     <= IDLE;
            rd_line_q   <= '0;
            beat_cnt_q  <= '0;
            err_q       <= '0;
            fbc_start_q <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            scan_q      <= 1'b0;
            restart_q   <= 1'b0;
            ignore_q    <= 1'b1;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            slice_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_line_q   <= rd_line_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            fbc_start_q <= fbc_start_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            scan_q      <= scan_en_i;
            restart_q   <= restart_d;
            ignore_q    <= ignore_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            slice_q     <= slice_d;
        end
    end

`ifdef FBC_VOUT_FWFT_EN
    assign vout_rd_vld_o  = (level_q != '0);
    assign vout_rd_data_o = (level_q != '0) ? slice_word : '0;
`else
    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        vld_d  = rd_fire;
        data_d = rd_fire ? slice_word : data_q;
    end

    always_ff @(posedge ddr_clk_i) begin
        if (ddr_rst_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vout_rd_vld_o  = vld_q;
    assign vout_rd_data_o = data_q;
`endif

    assign rd_burst_line_o = rd_line_q;
    assign fbc_start_o     = fbc_start_q;
    assign rd_ddr_req_o    = req_q;
    assign rd_ddr_len_o    = 8'(BURST_LEN);
    assign rd_ddr_addr_o   = addr_q;
    assign vout_empty_o    = (level_q == '0);
    assign vout_level_o    = level_q;
    assign err_o           = err_q;
endmodule

// File: tb/tb_fbc_vout_burst_reader.sv
// tb/tb_fbc_vout_burst_reader.sv - directed table-driven bench for fbc_vout_burst_reader.
module tb_fbc_vout_burst_reader;
    localparam int AWD = 30;
    localparam int DW  = 32;
    localparam int MW  = 256;
    localparam int BL  = 4;
    localparam int LNW = 3;
    localparam int RL  = 4;
    localparam int BD  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           scan_en;
    logic [LNW-1:0] wr_line;
    logic [LNW-1:0] rd_line;
    logic           fbc_start;
    logic           req;
    logic [7:0]     len;
    logic [AWD-1:0] addr;
    logic           dvalid;
    logic [MW-1:0]  ddata;
    logic           finish;
    logic           rd_en;
    logic           vld;
    logic [DW-1:0]  rdata;
    logic           empty;
    logic [3:0]     level;
    logic [1:0]     err;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int r0;
    bit ok;

    fbc_vout_burst_reader #(
        .ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .MEM_DATA_BITS(MW), .BURST_LEN(BL),
        .LINE_WIDTH(LNW), .RING_LINES(RL), .BASE_ADDR(30'h100), .BUF_DEPTH(BD)
    ) dut (
        .ddr_clk_i(clk), .ddr_rst_i(rst), .scan_en_i(scan_en),
        .wr_burst_line_i(wr_line), .rd_burst_line_o(rd_line), .fbc_start_o(fbc_start),
        .rd_ddr_req_o(req), .rd_ddr_len_o(len), .rd_ddr_addr_o(addr),
        .rd_ddr_data_valid_i(dvalid), .rd_ddr_data_i(ddata), .rd_ddr_finish_i(finish),
        .vout_rd_en_i(rd_en), .vout_rd_vld_o(vld), .vout_rd_data_o(rdata),
        .vout_empty_o(empty), .vout_level_o(level), .err_o(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (req) req_cnt <= req_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int             line;
        int             wr;
        int             nb;
        logic [AWD-1:0] exp_addr;
        int             exp_rd;
        logic [1:0]     exp_err;
    } vec_t;

    vec_t tbl [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int line, input int w);
        return {8'hA5, 8'(line), 8'(w / 8), 8'(w % 8)};
    endfunction

    function automatic logic [MW-1:0] mk_beat(input int line, input int b);
        logic [MW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = exp_word(line, b * 8 + i);
        return r;
    endfunction

    task automatic wait_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (req) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no request expected request within 60 cycles");
        end
    endtask

    task automatic drive_burst(input int line, input int nb);
        for (int b = 0; b < nb; b++) begin
            dvalid = 1'b1;
            ddata  = mk_beat(line, b);
            step();
        end
        dvalid = 1'b0;
        finish = 1'b1;
        step();
        finish = 1'b0;
    endtask

    task automatic read_words(input int line, input int first, input int cnt);
`ifdef FBC_VOUT_FWFT_EN
        for (int w = 0; w < cnt; w++) begin
            chk("fwft_vld", 256'(vld), 256'(1));
            chk("fwft_data", 256'(rdata), 256'(exp_word(line, first + w)));
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
        end
`else
        rd_en = 1'b1;
        for (int w = 0; w < cnt; w++) begin
            step();
            chk("rd_vld", 256'(vld), 256'(1));
            chk("rd_data", 256'(rdata), 256'(exp_word(line, first + w)));
        end
        rd_en = 1'b0;
        step();
`endif
    endtask

    initial begin
        tbl[0] = '{0, 1, 4, 30'h100, 1, 2'b00};
        tbl[1] = '{1, 2, 4, 30'h180, 2, 2'b00};
        tbl[2] = '{2, 3, 4, 30'h200, 3, 2'b00};
        tbl[3] = '{3, 4, 4, 30'h280, 4, 2'b00};
        tbl[4] = '{4, 5, 4, 30'h100, 5, 2'b00};
        tbl[5] = '{5, 6, 3, 30'h180, 6, 2'b10};
        tbl[6] = '{6, 7, 4, 30'h200, 7, 2'b10};
        tbl[7] = '{7, 0, 4, 30'h280, 0, 2'b10};
        tbl[8] = '{0, 1, 4, 30'h100, 1, 2'b10};

        rst = 1'b1; scan_en = 1'b0; wr_line = '0; dvalid = 1'b0; ddata = '0;
        finish = 1'b0; rd_en = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_rd_line", 256'(rd_line), 256'(0));
        chk("rst_fbc_start", 256'(fbc_start), 256'(0));
        chk("rst_req", 256'(req), 256'(0));
        chk("rst_len", 256'(len), 256'(4));
        chk("rst_addr", 256'(addr), 256'(0));
        chk("rst_vld", 256'(vld), 256'(0));
        chk("rst_data", 256'(rdata), 256'(0));
        chk("rst_empty", 256'(empty), 256'(1));
        chk("rst_level", 256'(level), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("empty_read_vld", 256'(vld), 256'(0));

        scan_en = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            wr_line = LNW'(tbl[i].wr);
            wait_req(ok);
            if (ok) begin
                chk("burst_addr", 256'(addr), 256'(tbl[i].exp_addr));
                chk("burst_len", 256'(len), 256'(4));
                drive_burst(tbl[i].line, tbl[i].nb);
                step();
                chk("burst_rd_line", 256'(rd_line), 256'(tbl[i].exp_rd));
                chk("burst_err", 256'(err), 256'(tbl[i].exp_err));
                chk("burst_fbc_start", 256'(fbc_start), 256'(1));
                chk("burst_level", 256'(level), 256'(tbl[i].nb));
                read_words(tbl[i].line, 0, tbl[i].nb * 8);
                chk("burst_drained", 256'(empty), 256'(1));
            end
        end
        chk("table_req_count", 256'(req_cnt), 256'(9));

        dvalid = 1'b1;
        ddata  = mk_beat(9, 0);
        step();
        dvalid = 1'b0;
        step();
        step();
        chk("stray_err", 256'(err), 256'(3));
        chk("stray_level", 256'(level), 256'(0));

        r0 = req_cnt;
        wr_line = 3'd6;
        wait_req(ok);
        chk("stall_addr1", 256'(addr), 256'(30'h180));
        drive_burst(1, 4);
        wait_req(ok);
        chk("stall_addr2", 256'(addr), 256'(30'h200));
        drive_burst(2, 4);
        repeat (30) step();
        chk("stall_req_count", 256'(req_cnt), 256'(r0 + 2));
        chk("stall_level_full", 256'(level), 256'(8));
        read_words(1, 0, 31);
        repeat (10) step();
        chk("stall_level5", 256'(level), 256'(5));
        chk("stall_no_req_at5", 256'(req_cnt), 256'(r0 + 2));
        read_words(1, 31, 1);
        wait_req(ok);
        chk("stall_addr3", 256'(addr), 256'(30'h280));

        scan_en = 1'b0;
        drive_burst(3, 4);
        step();
        chk("drop_rd_line", 256'(rd_line), 256'(4));
        chk("drop_fbc_start", 256'(fbc_start), 256'(0));
        read_words(2, 0, 32);
        read_words(3, 0, 32);
        repeat (20) step();
        chk("drop_no_req", 256'(req_cnt), 256'(r0 + 3));
        chk("drop_empty", 256'(empty), 256'(1));

        wr_line = 3'd0;
        scan_en = 1'b1;
        step();
        step();
        chk("rise_rd_line", 256'(rd_line), 256'(0));
        chk("rise_level", 256'(level), 256'(0));
        chk("rise_empty", 256'(empty), 256'(1));
        repeat (10) step();
        chk("rise_no_req", 256'(req_cnt), 256'(r0 + 3));

        wr_line = 3'd1;
        wait_req(ok);
        chk("lat_addr", 256'(addr), 256'(30'h100));
        drive_burst(0, 4);
        step();
        step();
`ifdef FBC_VOUT_FWFT_EN
        chk("fwft_empty", 256'(empty), 256'(0));
        chk("fwft_vld_early", 256'(vld), 256'(1));
        chk("fwft_data_early", 256'(rdata), 256'(exp_word(0, 0)));
`else
        chk("lat_vld_idle", 256'(vld), 256'(0));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("lat_vld_1cyc", 256'(vld), 256'(1));
        chk("lat_data", 256'(rdata), 256'(exp_word(0, 0)));
        step();
        chk("lat_vld_pulse", 256'(vld), 256'(0));
`endif
        chk("final_fbc_start", 256'(fbc_start), 256'(1));
        chk("final_rd_line", 256'(rd_line), 256'(1));
        chk("final_err", 256'(err), 256'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
